// File: rtl/memshare_bank_responder.sv
// rtl/memshare_bank_responder.sv - memShare responder: bank-conflict allocation, IB-LUT reads, per-requestor responses
module memshare_bank_responder #(
    parameter int SHARE_GROUP_SIZE   = 5,
    parameter int RQST_ADDR_BITWIDTH = 2,
    parameter int BANK_NUM           = 4,
    parameter int ROW_ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH         = 4,
    parameter int MAX_ALLOC_SEQ_NUM  = 2,
    parameter int RD_LATENCY         = 1
) (
    input  logic                                         sys_clk,
    input  logic                                         rstn,
    input  logic                                         rqst_valid,
    output logic                                         rqst_ready,
    input  logic [SHARE_GROUP_SIZE-1:0]                  rqst_en,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_col_addr,
    input  logic [SHARE_GROUP_SIZE*ROW_ADDR_WIDTH-1:0]   rqst_row_addr,
    output logic [BANK_NUM-1:0]                          bank_rd_en,
    output logic [BANK_NUM*ROW_ADDR_WIDTH-1:0]           bank_rd_addr,
    input  logic [BANK_NUM*DATA_WIDTH-1:0]               bank_rd_data,
    output logic [SHARE_GROUP_SIZE-1:0]                  rsp_valid,
    output logic [SHARE_GROUP_SIZE*DATA_WIDTH-1:0]       rsp_data,
    output logic                                         rsp_seq_id,
    output logic                                         rsp_done,
    output logic                                         alloc_overflow
);
    localparam int SG = SHARE_GROUP_SIZE;
    localparam int AW = RQST_ADDR_BITWIDTH;
    localparam int RW = ROW_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int L  = RD_LATENCY;
    localparam logic          SEQ1_ID  = 1'(MAX_ALLOC_SEQ_NUM - 1);
    localparam logic [RW-1:0] ROW_FULL = '1;
    localparam logic [RW-1:0] GP1_MASK = ROW_FULL >> 1;

    typedef enum logic [1:0] {IDLE, SEQ0, SEQ1, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [SG-1:0]              pending_q, pending_d;
    logic [SG*AW-1:0]           col_q, col_d;
    logic [SG*RW-1:0]           row_q, row_d;
    logic [L-1:0][SG-1:0]       grant_pipe_q, grant_pipe_d;
    logic [L-1:0][SG*AW-1:0]    sel_pipe_q, sel_pipe_d;
    logic [L-1:0]               seq_pipe_q, seq_pipe_d;
    logic [L-1:0]               last_pipe_q, last_pipe_d;
    logic [SG-1:0]              rsp_valid_q, rsp_valid_d;
    logic [SG*DW-1:0]           rsp_data_q, rsp_data_d;
    logic                       rsp_seq_id_q, rsp_seq_id_d;
    logic                       rsp_done_q, rsp_done_d;
    logic                       alloc_overflow_q, alloc_overflow_d;

    logic                       issue;
    logic [RW-1:0]              eff_row [SG];
    logic [BANK_NUM-1:0]        leader_vld;
    logic [RW-1:0]              leader_row [BANK_NUM];
    logic [SG-1:0]              grant, pending_nxt;
    logic [AW-1:0]              rsp_sel;

    assign issue = (state_q == SEQ0) || (state_q == SEQ1);

    // GP1 banks (even column address) ignore the row MSB, so rows differing only there merge.
    always_comb begin
        leader_vld = '0;
        grant      = '0;
        for (int b = 0; b < BANK_NUM; b++) leader_row[b] = '0;
        for (int i = 0; i < SG; i++)
            eff_row[i] = row_q[i*RW +: RW] & (col_q[i*AW] ? ROW_FULL : GP1_MASK);
        // Descending scan leaves the lowest-index pending requestor as each bank's leader.
        for (int i = SG - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                leader_vld[col_q[i*AW +: AW]] = 1'b1;
                leader_row[col_q[i*AW +: AW]] = eff_row[i];
            end
        end
        for (int i = 0; i < SG; i++)
            if (pending_q[i] && (eff_row[i] == leader_row[col_q[i*AW +: AW]])) grant[i] = 1'b1;
        pending_nxt = pending_q & ~grant;
    end

    always_comb begin
        bank_rd_en   = '0;
        bank_rd_addr = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_rd_en[b] = issue & leader_vld[b];
            if (bank_rd_en[b]) bank_rd_addr[b*RW +: RW] = leader_row[b];
        end
    end

    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q;
        col_d            = col_q;
        row_d            = row_q;
        alloc_overflow_d = 1'b0;
        case (state_q)
            IDLE: if (rqst_valid) begin
                col_d     = rqst_col_addr;
                row_d     = rqst_row_addr;
                pending_d = rqst_en;
                state_d   = (|rqst_en) ? SEQ0 : DRAIN;
            end
            SEQ0: begin
                pending_d = pending_nxt;
                state_d   = (|pending_nxt) ? SEQ1 : DRAIN;
            end
            SEQ1: begin
                pending_d        = pending_nxt;
                alloc_overflow_d = |pending_nxt;
                state_d          = DRAIN;
            end
            DRAIN: if (rsp_done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant/select/seq travel alongside the bank read so the last stage lines up with bank_rd_data.
    always_comb begin
        grant_pipe_d    = grant_pipe_q;
        sel_pipe_d      = sel_pipe_q;
        seq_pipe_d      = seq_pipe_q;
        last_pipe_d     = last_pipe_q;
        grant_pipe_d[0] = issue ? grant : '0;
        sel_pipe_d[0]   = col_q;
        seq_pipe_d[0]   = (state_q == SEQ1) ? SEQ1_ID : 1'b0;
        last_pipe_d[0]  = (state_q == SEQ1) || ((state_q == SEQ0) && (pending_nxt == '0));
        for (int k = 1; k < L; k++) begin
            grant_pipe_d[k] = grant_pipe_q[k-1];
            sel_pipe_d[k]   = sel_pipe_q[k-1];
            seq_pipe_d[k]   = seq_pipe_q[k-1];
            last_pipe_d[k]  = last_pipe_q[k-1];
        end
    end

    always_comb begin
        rsp_valid_d  = grant_pipe_q[L-1];
        rsp_data_d   = '0;
        rsp_sel      = '0;
        for (int i = 0; i < SG; i++) begin
            rsp_sel = sel_pipe_q[L-1][i*AW +: AW];
            if (rsp_valid_d[i]) rsp_data_d[i*DW +: DW] = bank_rd_data[rsp_sel*DW +: DW];
        end
        rsp_seq_id_d = (|grant_pipe_q[L-1]) & seq_pipe_q[L-1];
        rsp_done_d   = ((state_q == IDLE) && rqst_valid && (rqst_en == '0)) || last_pipe_q[L-1];
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            pending_q        <= '0;
            col_q            <= '0;
            row_q            <= '0;
            grant_pipe_q     <= '0;
            sel_pipe_q       <= '0;
            seq_pipe_q       <= '0;
            last_pipe_q      <= '0;
            rsp_valid_q      <= '0;
            rsp_data_q       <= '0;
            rsp_seq_id_q     <= 1'b0;
            rsp_done_q       <= 1'b0;
            alloc_overflow_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            col_q            <= col_d;
            row_q            <= row_d;
            grant_pipe_q     <= grant_pipe_d;
            sel_pipe_q       <= sel_pipe_d;
            seq_pipe_q       <= seq_pipe_d;
            last_pipe_q      <= last_pipe_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            rsp_seq_id_q     <= rsp_seq_id_d;
            rsp_done_q       <= rsp_done_d;
            alloc_overflow_q <= alloc_overflow_d;
        end
    end

    assign rqst_ready     = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_seq_id     = rsp_seq_id_q;
    assign rsp_done       = rsp_done_q;
    assign alloc_overflow = alloc_overflow_q;

endmodule

// File: tb/tb_memshare_bank_responder.sv
// tb/tb_memshare_bank_responder.sv - directed bench for memshare_bank_responder (latency 1 and 3 instances)
module tb_memshare_bank_responder;
    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        rqst_valid;
    logic [4:0]  rqst_en;
    logic [9:0]  rqst_col_addr;
    logic [29:0] rqst_row_addr;

    logic        rqst_ready, rqst_ready3;
    logic [3:0]  bank_rd_en, bank_rd_en3;
    logic [23:0] bank_rd_addr, bank_rd_addr3;
    logic [15:0] bank_rd_data, bank_rd_data3;
    logic [4:0]  rsp_valid, rsp_valid3;
    logic [19:0] rsp_data, rsp_data3;
    logic        rsp_seq_id, rsp_seq_id3;
    logic        rsp_done, rsp_done3;
    logic        alloc_overflow, alloc_overflow3;
    logic [15:0] m3_q [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    memshare_bank_responder #(.RD_LATENCY(1)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .rqst_valid(rqst_valid), .rqst_ready(rqst_ready),
        .rqst_en(rqst_en), .rqst_col_addr(rqst_col_addr), .rqst_row_addr(rqst_row_addr),
        .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_seq_id(rsp_seq_id),
        .rsp_done(rsp_done), .alloc_overflow(alloc_overflow));

    memshare_bank_responder #(.RD_LATENCY(3)) dut3 (
        .sys_clk(sys_clk), .rstn(rstn), .rqst_valid(rqst_valid), .rqst_ready(rqst_ready3),
        .rqst_en(rqst_en), .rqst_col_addr(rqst_col_addr), .rqst_row_addr(rqst_row_addr),
        .bank_rd_en(bank_rd_en3), .bank_rd_addr(bank_rd_addr3), .bank_rd_data(bank_rd_data3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_seq_id(rsp_seq_id3),
        .rsp_done(rsp_done3), .alloc_overflow(alloc_overflow3));

    function automatic logic [3:0] mem_val(input int b, input logic [5:0] a);
        return 4'(int'(a) + 3 * b + 1);
    endfunction

    // Bank data is present only in the one cycle RD_LATENCY after the enable, zero otherwise.
    always @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            bank_rd_data <= '0;
            for (int k = 0; k < 3; k++) m3_q[k] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                bank_rd_data[b*4 +: 4] <= bank_rd_en[b] ? mem_val(b, bank_rd_addr[b*6 +: 6]) : 4'h0;
                m3_q[0][b*4 +: 4]      <= bank_rd_en3[b] ? mem_val(b, bank_rd_addr3[b*6 +: 6]) : 4'h0;
            end
            m3_q[1] <= m3_q[0];
            m3_q[2] <= m3_q[1];
        end
    end
    assign bank_rd_data3 = m3_q[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] rows(input logic [5:0] r0, r1, r2, r3, r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rqst_ready && rqst_ready3) && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 40) check("ready_timeout", {rqst_ready, rqst_ready3}, 2'b11);
    endtask

    // Presents a pattern for one cycle; returns in the cycle after capture.
    task automatic send(input logic [4:0] en, input logic [9:0] col, input logic [29:0] row);
        wait_ready();
        rqst_valid    = 1'b1;
        rqst_en       = en;
        rqst_col_addr = col;
        rqst_row_addr = row;
        @(negedge sys_clk);
        rqst_valid    = 1'b0;
        rqst_en       = '0;
    endtask

    initial begin
        logic stale;
        rstn = 1'b0; rqst_valid = 1'b0; rqst_en = '0; rqst_col_addr = '0; rqst_row_addr = '0;
        step(2);
        check("rst_ready", rqst_ready, 1'b1);
        check("rst_bank_en", bank_rd_en, 4'h0);
        check("rst_bank_addr", bank_rd_addr, 24'h0);
        check("rst_rsp_valid", rsp_valid, 5'h0);
        check("rst_rsp_data", rsp_data, 20'h0);
        check("rst_flags", {rsp_seq_id, rsp_done, alloc_overflow}, 3'b000);
        rstn = 1'b1;
        step(1);

        // all banks, requestors 0 and 4 share bank0 row 5
        send(5'h1F, 10'b00_11_10_01_00, rows(5, 1, 2, 3, 5));
        check("t1_bank_en", bank_rd_en, 4'hF);
        check("t1_bank_addr", bank_rd_addr, {6'd3, 6'd2, 6'd1, 6'd5});
        check("t1_busy", rqst_ready, 1'b0);
        step(1);
        check("t1_early_valid", rsp_valid, 5'h0);
        step(1);
        check("t1_rsp_valid", rsp_valid, 5'h1F);
        check("t1_rsp_data", rsp_data, 20'h6D956);
        check("t1_seq_done", {rsp_seq_id, rsp_done}, 2'b01);
        check("t1_lat3_early", rsp_valid3, 5'h0);
        step(1);
        check("t1_ready_back", rqst_ready, 1'b1);
        check("t1_valid_1cyc", {rsp_valid, rsp_done}, 6'h0);
        check("t1_lat3_early2", rsp_valid3, 5'h0);
        step(1);
        check("t1_lat3_valid", rsp_valid3, 5'h1F);
        check("t1_lat3_data", rsp_data3, 20'h6D956);
        check("t1_lat3_done", rsp_done3, 1'b1);

        // bank conflict: two sequences
        send(5'h1F, 10'b00_00_01_01_01, rows(3, 7, 3, 2, 2));
        check("t2_seq0_en", bank_rd_en, 4'b0011);
        check("t2_seq0_addr", bank_rd_addr, {6'd0, 6'd0, 6'd3, 6'd2});
        step(1);
        check("t2_seq1_en", bank_rd_en, 4'b0010);
        check("t2_seq1_addr", bank_rd_addr, {6'd0, 6'd0, 6'd7, 6'd0});
        step(1);
        check("t2_rsp0_valid", rsp_valid, 5'b11101);
        check("t2_rsp0_data", rsp_data, 20'h33707);
        check("t2_rsp0_flags", {rsp_seq_id, rsp_done, alloc_overflow}, 3'b000);
        step(1);
        check("t2_rsp1_valid", rsp_valid, 5'b00010);
        check("t2_rsp1_data", rsp_data, 20'h000B0);
        check("t2_rsp1_flags", {rsp_seq_id, rsp_done}, 2'b11);

        // three distinct rows on bank2: overflow
        send(5'h1F, 10'b10_10_10_10_10, rows(1, 2, 3, 1, 4));
        check("t3_seq0_en", bank_rd_en, 4'b0100);
        check("t3_seq0_addr", bank_rd_addr, {6'd0, 6'd1, 6'd0, 6'd0});
        step(1);
        check("t3_seq1_addr", bank_rd_addr, {6'd0, 6'd2, 6'd0, 6'd0});
        step(1);
        check("t3_rsp0_valid", rsp_valid, 5'b01001);
        check("t3_rsp0_data", rsp_data, 20'h08008);
        check("t3_ovf_pulse", {alloc_overflow, rsp_done}, 2'b10);
        step(1);
        check("t3_rsp1_valid", rsp_valid, 5'b00010);
        check("t3_rsp1_data", rsp_data, 20'h00090);
        check("t3_rsp1_flags", {rsp_seq_id, rsp_done, alloc_overflow}, 3'b110);
        step(1);
        check("t3_no_unserved", {rsp_valid, alloc_overflow}, 6'h0);

        // empty pattern
        send(5'h00, 10'h0, 30'h0);
        check("t4_no_read", bank_rd_en, 4'h0);
        check("t4_done", {rsp_done, rqst_ready, rsp_valid}, 7'b1000000);
        step(1);
        check("t4_ready_back", {rqst_ready, rsp_done}, 2'b10);

        // reset during SEQ1
        send(5'h1F, 10'b00_00_01_01_01, rows(3, 7, 3, 2, 2));
        step(1);
        check("t5_in_seq1", bank_rd_en, 4'b0010);
        #1 rstn = 1'b0;
        #1;
        check("t5_rst_outputs", {bank_rd_en, bank_rd_addr, rsp_valid, rsp_done}, 34'h0);
        check("t5_rst_ready", rqst_ready, 1'b1);
        step(1);
        rstn = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            stale = stale | (|rsp_valid) | rsp_done | (|bank_rd_en);
        end
        check("t5_no_stale", stale, 1'b0);
        check("t5_ready_after", rqst_ready, 1'b1);
        send(5'h1F, 10'b00_11_10_01_00, rows(5, 1, 2, 3, 5));
        step(2);
        check("t5_resume_valid", rsp_valid, 5'h1F);
        check("t5_resume_data", rsp_data, 20'h6D956);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/memshare_bank_responder.md
Name: memshare_bank_responder

Overview:
- Responder end of the memShare access-request interface. It accepts one request pattern per transaction from the access-request generator: 5 requestors, each with a column-bank address and a row address.
- It resolves bank conflicts into at most MAX_ALLOC_SEQ_NUM allocation sequences, issues reads to the four column-bank IB-LUT ports (GP1/GP2 × bank0/bank1), and returns per-requestor read data.
- It sits between the access-request generator and the column-bank IB-LUT memories.

Parameters:
- SHARE_GROUP_SIZE, 5, number of requestors in a share group.
- RQST_ADDR_BITWIDTH, 2, column-bank address width; 0=GP1_BANK0, 2=GP1_BANK1, 1=GP2_BANK0, 3=GP2_BANK1.
- BANK_NUM, 4, number of column banks (2**RQST_ADDR_BITWIDTH).
- ROW_ADDR_WIDTH, 6, bank read-address width (GP2_RD_ADDR_WIDTH); GP1 banks use the low 5 bits, upper bit ignored.
- DATA_WIDTH, 4, read data width (QUAN_SIZE).
- MAX_ALLOC_SEQ_NUM, 2, maximum allocation sequences per pattern.
- RD_LATENCY, 1, bank read latency in cycles (≥1).

Ports:
- sys_clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- rqst_valid  in  1  request pattern valid.
- rqst_ready  out  1  responder can accept a pattern.
- rqst_en  in  SHARE_GROUP_SIZE  per-requestor enable.
- rqst_col_addr  in  SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  column-bank address; requestor i at [i*2+:2].
- rqst_row_addr  in  SHARE_GROUP_SIZE*ROW_ADDR_WIDTH  row read address per requestor.
- bank_rd_en  out  BANK_NUM  bank read enable.
- bank_rd_addr  out  BANK_NUM*ROW_ADDR_WIDTH  bank read address.
- bank_rd_data  in  BANK_NUM*DATA_WIDTH  bank read data, valid RD_LATENCY cycles after bank_rd_en.
- rsp_valid  out  SHARE_GROUP_SIZE  per-requestor response valid.
- rsp_data  out  SHARE_GROUP_SIZE*DATA_WIDTH  per-requestor read data.
- rsp_seq_id  out  1  allocation sequence index of the current responses.
- rsp_done  out  1  one-cycle pulse: pattern fully served.
- alloc_overflow  out  1  one-cycle pulse: requestors left unserved after the last sequence.

Behaviour:
- Reset (rstn=0, async) forces:
  - FSM to IDLE, rqst_ready=1.
  - bank_rd_en, rsp_valid, rsp_seq_id, rsp_done and alloc_overflow to 0.
  - bank_rd_addr and rsp_data to 0.
  - Captured pattern, pending mask and grant pipeline cleared.
- Reset mid-transaction drops all in-flight reads and responses; no rsp_done is issued.
- FSM states: IDLE, SEQ0, SEQ1, DRAIN.
- IDLE:
  - rqst_ready=1.
  - On rqst_valid&rqst_ready, capture en/col/row and set pending=rqst_en.
  - Next state is SEQ0 if pending≠0, otherwise DRAIN with an empty pattern.
- SEQ0/SEQ1 (one cycle each, rqst_ready=0):
  - For each bank b, the lowest-index pending requestor with col_addr==b is the leader.
  - bank_rd_en[b]=1 and bank_rd_addr[b]=leader row; both are combinational from the captured registers in this cycle.
  - Grant = every pending requestor whose col_addr==b and row==leader row (broadcast merge). Clear granted bits from pending.
  - Granted requestors of different banks are independent.
  - SEQ0→SEQ1 if pending≠0 after the grant, otherwise →DRAIN.
  - SEQ1→DRAIN always. If pending≠0 after the SEQ1 grant, pulse alloc_overflow in the cycle after SEQ1; those requestors never receive rsp_valid.
- Response path:
  - The grant mask, seq id and per-requestor bank select are delayed RD_LATENCY cycles.
  - rsp_valid[i]=1 and rsp_data[i]=bank_rd_data[col_addr_i], registered.
  - Responses for an issue in cycle c appear in cycle c+RD_LATENCY+1.
  - rsp_seq_id = 0 for SEQ0 responses, 1 for SEQ1 responses.
  - rsp_valid and rsp_data hold for exactly one cycle; rsp_data is 0 where rsp_valid=0.
- DRAIN:
  - Wait until the last issued sequence's responses are output; rsp_done pulses in that same cycle, then IDLE.
  - rqst_ready=1 in the cycle after rsp_done.
  - Empty pattern: rsp_done pulses in the cycle after capture, with no bank reads and no rsp_valid.
- There are no back-to-back patterns: rqst_valid asserted while rqst_ready=0 is ignored and held by the sender.
- Overflow and rsp_done relation:
  - Overflow occurs only when one bank sees more than 2 distinct rows among pending requestors.
  - rsp_done still pulses after the served responses.

Test Plan:
- All 5 requestors enabled on distinct banks, with col={0,1,2,3,0} and row 0 equal to row 4 (=5): SEQ0 only.
  - bank_rd_en=4'b1111 in the cycle after capture.
  - rsp_valid=5'b11111 with rsp_seq_id=0 at capture+3 (RD_LATENCY=1); rsp_done in the same cycle.
- Conflict case: col={1,1,1,0,0}, row={3,7,3,2,2}.
  - SEQ0 grants 5'b11101 with bank1 addr=3 and bank0 addr=2.
  - SEQ1 grants requestor1 with bank1 addr=7.
  - rsp_seq_id goes 0 then 1 on consecutive cycles; rsp_done coincides with the second response.
- Overflow case: col all 2, row={1,2,3,1,4}.
  - SEQ0 grants {0,3}; SEQ1 grants {1}; alloc_overflow pulses once.
  - Requestors 2 and 4 never assert rsp_valid; rsp_done still pulses.
- Empty pattern (rqst_en=0) with rqst_valid=1: bank_rd_en stays 0, rsp_done pulses at capture+1, and rqst_ready returns at capture+2.
- Reset and latency cases:
  - Assert rstn=0 during SEQ1: all outputs go to 0 immediately and rqst_ready=1 after release, with no stale rsp_valid. A new pattern is then served correctly.
  - With RD_LATENCY=3: SEQ0 responses appear at capture+5, and bank_rd_data is sampled exactly 3 cycles after bank_rd_en.
